id_ex_stage_buffer: RTL and testbench

- ID/EX pipeline register for the 5-stage RISCV core. Captures decoded operands and control from ID, and presents the opcode, rs1/rs2 indices and operand data consumed by the forwarding controller and the EX stage.
- Detects load-use hazards, freezes PC and IF/ID, and inserts exactly one bubble so that the load result can later be forwarded from MEM/WB.
- Applies branch flushes from EX.

---
 rtl/id_ex_stage_buffer_if.sv | 46 ++++
 rtl/id_ex_stage_buffer.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage_buffer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_buffer_if.sv
// ID -> ID/EX -> EX/forwarding signal bundle for id_ex_stage_buffer.
// The slave modport is the pipeline register; the master modport is the surrounding core.
interface id_ex_stage_buffer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);
  logic              id_valid_ip;
  logic [6:0]        id_opcode_ip;
  logic [REG_AW-1:0] id_rs1_ip;
  logic [REG_AW-1:0] id_rs2_ip;
  logic [REG_AW-1:0] id_rd_ip;
  logic [1:0]        id_wb_mux_ip;
  logic [DATA_W-1:0] id_rs1_data_ip;
  logic [DATA_W-1:0] id_rs2_data_ip;
  logic [DATA_W-1:0] id_imm_ip;
  logic [DATA_W-1:0] id_pc_ip;
  logic              flush_ip;

  logic              idex_valid_op;
  logic [6:0]        idex_opcode_op;
  logic [REG_AW-1:0] idex_rs1_op;
  logic [REG_AW-1:0] idex_rs2_op;
  logic [REG_AW-1:0] idex_rd_op;
  logic [1:0]        idex_wb_mux_op;
  logic [DATA_W-1:0] idex_rs1_data_op;
  logic [DATA_W-1:0] idex_rs2_data_op;
  logic [DATA_W-1:0] idex_imm_op;
  logic [DATA_W-1:0] idex_pc_op;
  logic              stall_op;

  modport master (
    output id_valid_ip, id_opcode_ip, id_rs1_ip, id_rs2_ip, id_rd_ip, id_wb_mux_ip,
           id_rs1_data_ip, id_rs2_data_ip, id_imm_ip, id_pc_ip, flush_ip,
    input  idex_valid_op, idex_opcode_op, idex_rs1_op, idex_rs2_op, idex_rd_op,
           idex_wb_mux_op, idex_rs1_data_op, idex_rs2_data_op, idex_imm_op, idex_pc_op,
           stall_op
  );

  modport slave (
    input  id_valid_ip, id_opcode_ip, id_rs1_ip, id_rs2_ip, id_rd_ip, id_wb_mux_ip,
           id_rs1_data_ip, id_rs2_data_ip, id_imm_ip, id_pc_ip, flush_ip,
    output idex_valid_op, idex_opcode_op, idex_rs1_op, idex_rs2_op, idex_rd_op,
           idex_wb_mux_op, idex_rs1_data_op, idex_rs2_data_op, idex_imm_op, idex_pc_op,
           stall_op
  );
endinterface

// File: rtl/id_ex_stage_buffer.sv
// ID/EX pipeline register with load-use hazard detection (one bubble) and EX branch flush.
// Optional macro IDEX_STALL_CNT_EN adds a saturating 32-bit count of inserted load-use bubbles.
module id_ex_stage_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  id_ex_stage_buffer_if.slave  bus
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt_op
`endif
);

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    NO_WRITEBACK = 2'd0,
    WB_ALU       = 2'd1,
    WB_MEM       = 2'd2,
    WB_PC4       = 2'd3
  } write_back_mux_selector_e;

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  state_e                   state_q, state_d;
  logic                     valid_q, valid_d;
  logic [6:0]               opcode_q, opcode_d;
  logic [REG_AW-1:0]        rd_q, rd_d;
  write_back_mux_selector_e wb_q, wb_d;
  logic [REG_AW-1:0]        rs1_q, rs2_q;
  logic [DATA_W-1:0]        rs1_data_q, rs2_data_q, imm_q, pc_q;

  logic uses_rs1, uses_rs2, hazard, capture, load_instr;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (bus.id_opcode_ip)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = (state_q == StRun) && valid_q && (opcode_q == OPCODE_LOAD) &&
                  (rd_q != '0) && bus.id_valid_ip &&
                  ((uses_rs1 && (bus.id_rs1_ip == rd_q)) ||
                   (uses_rs2 && (bus.id_rs2_ip == rd_q)));

  assign bus.stall_op = hazard && !bus.flush_ip;

  // Defaults describe a bubble; only a captured valid instruction overrides them.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    valid_d  = 1'b0;
    opcode_d = '0;
    rd_d     = '0;
    wb_d     = NO_WRITEBACK;
    if (bus.flush_ip) begin
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hazard) state_d = StBubble;
          else        capture = 1'b1;
        end
        StBubble: begin
          state_d = StRun;
          capture = 1'b1;
        end
        default: state_d = StRun;
      endcase
    end
    load_instr = capture && bus.id_valid_ip;
    if (load_instr) begin
      valid_d  = 1'b1;
      opcode_d = bus.id_opcode_ip;
      rd_d     = bus.id_rd_ip;
      wb_d     = write_back_mux_selector_e'(bus.id_wb_mux_ip);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      valid_q    <= 1'b0;
      opcode_q   <= '0;
      rd_q       <= '0;
      wb_q       <= NO_WRITEBACK;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      rd_q     <= rd_d;
      wb_q     <= wb_d;
      // Bubbles leave index/data fields stale; consumers gate on valid.
      if (load_instr) begin
        rs1_q      <= bus.id_rs1_ip;
        rs2_q      <= bus.id_rs2_ip;
        rs1_data_q <= bus.id_rs1_data_ip;
        rs2_data_q <= bus.id_rs2_data_ip;
        imm_q      <= bus.id_imm_ip;
        pc_q       <= bus.id_pc_ip;
      end
    end
  end

  assign bus.idex_valid_op    = valid_q;
  assign bus.idex_opcode_op   = opcode_q;
  assign bus.idex_rs1_op      = rs1_q;
  assign bus.idex_rs2_op      = rs2_q;
  assign bus.idex_rd_op       = rd_q;
  assign bus.idex_wb_mux_op   = wb_q;
  assign bus.idex_rs1_data_op = rs1_data_q;
  assign bus.idex_rs2_data_op = rs2_data_q;
  assign bus.idex_imm_op      = imm_q;
  assign bus.idex_pc_op       = pc_q;

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((state_q == StRun) && (state_d == StBubble) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_op = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_buffer.sv
// Bench for id_ex_stage_buffer: directed load-use/flush/reset scenarios plus a random stream
// checked against a cycle-level reference model of the hazard and bubble rules.
module tb_id_ex_stage_buffer;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] NO_WB = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] stall_cnt;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage_buffer_if #(.DATA_W(32), .REG_AW(5)) bus ();

  id_ex_stage_buffer #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IDEX_STALL_CNT_EN
    ,
    .stall_cnt_op (stall_cnt)
`endif
  );

`ifndef IDEX_STALL_CNT_EN
  assign stall_cnt = '0;
`endif

  // Reference model: expected ID/EX contents and bubble count.
  logic        m_valid;
  logic [6:0]  m_op;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [1:0]  m_wb;
  logic [31:0] m_d1, m_d2, m_imm, m_pc, m_cnt;

  function automatic logic reads_rs1(input logic [6:0] op);
    return op inside {OP_OP, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return op inside {OP_OP, OP_STORE, OP_BRANCH};
  endfunction

  // A load in ID/EX always follows either a capture or a flush, never a bubble, so the
  // one-bubble rule falls out of the bubble clearing valid.
  function automatic logic model_stall();
    logic match;
    match = (reads_rs1(bus.id_opcode_ip) && bus.id_rs1_ip == m_rd) ||
            (reads_rs2(bus.id_opcode_ip) && bus.id_rs2_ip == m_rd);
    return m_valid && m_op == OP_LOAD && m_rd != 5'd0 && bus.id_valid_ip && match &&
           !bus.flush_ip;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_wb = NO_WB;
    m_d1 = 0; m_d2 = 0; m_imm = 0; m_pc = 0; m_cnt = 0;
  endtask

  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [1:0] wb);
    bus.id_valid_ip    = v;
    bus.id_opcode_ip   = op;
    bus.id_rs1_ip      = rs1;
    bus.id_rs2_ip      = rs2;
    bus.id_rd_ip       = rd;
    bus.id_wb_mux_ip   = wb;
    bus.id_rs1_data_ip = $urandom;
    bus.id_rs2_data_ip = $urandom;
    bus.id_imm_ip      = $urandom;
    bus.id_pc_ip       = $urandom;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic s, take;
    s = model_stall();
    take = bus.id_valid_ip && !bus.flush_ip && !s;
    @(posedge clk);
    if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (take) begin
      m_valid = 1; m_op = bus.id_opcode_ip; m_rs1 = bus.id_rs1_ip; m_rs2 = bus.id_rs2_ip;
      m_rd = bus.id_rd_ip; m_wb = bus.id_wb_mux_ip; m_d1 = bus.id_rs1_data_ip;
      m_d2 = bus.id_rs2_data_ip; m_imm = bus.id_imm_ip; m_pc = bus.id_pc_ip;
    end else begin
      m_valid = 0; m_op = 0; m_rd = 0; m_wb = NO_WB;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.flush_ip = 0;
    set_id(0, 7'd0, 0, 0, 0, NO_WB);
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if (bus.idex_valid_op !== 1'b0 || bus.idex_opcode_op !== 7'd0 || bus.idex_rd_op !== 5'd0 ||
        bus.idex_wb_mux_op !== NO_WB || bus.stall_op !== 1'b0 || bus.idex_pc_op !== 32'd0 ||
        bus.idex_rs1_data_op !== 32'd0 || stall_cnt !== 32'd0)
      begin n_err++; $display("FAIL reset_state: valid=%b op=%h rd=%0d wb=%0d stall=%b pc=%h cnt=%0d, required all zero",
        bus.idex_valid_op, bus.idex_opcode_op, bus.idex_rd_op, bus.idex_wb_mux_op, bus.stall_op,
        bus.idex_pc_op, stall_cnt); end
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    logic [31:0] cnt0;
    cnt0 = m_cnt;
    set_id(1, OP_LOAD, 5'd1, 5'd0, 5'd5, WB_MEM);
    tick();
    n_vec++;
    if (bus.idex_opcode_op !== OP_LOAD || bus.idex_rd_op !== 5'd5 || bus.idex_valid_op !== 1'b1)
      begin n_err++; $display("FAIL load_capture: op=%h rd=%0d valid=%b, required %h 5 1",
        bus.idex_opcode_op, bus.idex_rd_op, bus.idex_valid_op, OP_LOAD); end
    set_id(1, OP_OP, 5'd5, 5'd2, 5'd6, WB_ALU);
    n_vec++;
    if (bus.stall_op !== 1'b1)
      begin n_err++; $display("FAIL load_use_stall: stall=%b, required 1", bus.stall_op); end
    tick();
    n_vec++;
    if (bus.idex_valid_op !== 1'b0 || bus.idex_wb_mux_op !== NO_WB || bus.stall_op !== 1'b0)
      begin n_err++; $display("FAIL bubble: valid=%b wb=%0d stall=%b, required 0 0 0",
        bus.idex_valid_op, bus.idex_wb_mux_op, bus.stall_op); end
    tick();
    n_vec++;
    if (bus.idex_opcode_op !== OP_OP || bus.idex_rs1_op !== 5'd5 || bus.idex_valid_op !== 1'b1 ||
        bus.idex_rs1_data_op !== m_d1)
      begin n_err++; $display("FAIL after_bubble: op=%h rs1=%0d valid=%b d1=%h, required %h 5 1 %h",
        bus.idex_opcode_op, bus.idex_rs1_op, bus.idex_valid_op, bus.idex_rs1_data_op, OP_OP, m_d1); end
`ifdef IDEX_STALL_CNT_EN
    n_vec++;
    if (stall_cnt !== cnt0 + 32'd1)
      begin n_err++; $display("FAIL stall_cnt_inc: cnt=%0d, required %0d", stall_cnt, cnt0 + 1); end
`endif
  endtask

  task automatic test_no_hazard();
    set_id(1, OP_LOAD, 5'd1, 5'd0, 5'd0, WB_MEM);
    tick();
    set_id(1, OP_OP, 5'd0, 5'd2, 5'd6, WB_ALU);
    n_vec++;
    if (bus.stall_op !== 1'b0)
      begin n_err++; $display("FAIL load_x0: stall=%b, required 0", bus.stall_op); end
    tick();
    set_id(1, OP_LOAD, 5'd1, 5'd0, 5'd5, WB_MEM);
    n_vec++;
    if (bus.idex_opcode_op !== OP_OP || bus.idex_valid_op !== 1'b1 || bus.idex_rd_op !== 5'd6)
      begin n_err++; $display("FAIL x0_pass: op=%h valid=%b rd=%0d, required %h 1 6",
        bus.idex_opcode_op, bus.idex_valid_op, bus.idex_rd_op, OP_OP); end
    tick();
    set_id(1, OP_OPIMM, 5'd3, 5'd0, 5'd7, WB_ALU);
    n_vec++;
    if (bus.stall_op !== 1'b0)
      begin n_err++; $display("FAIL addi_indep: stall=%b, required 0", bus.stall_op); end
    tick();
    n_vec++;
    if (bus.idex_opcode_op !== OP_OPIMM || bus.idex_rd_op !== 5'd7 || bus.idex_imm_op !== m_imm)
      begin n_err++; $display("FAIL addi_pass: op=%h rd=%0d imm=%h, required %h 7 %h",
        bus.idex_opcode_op, bus.idex_rd_op, bus.idex_imm_op, OP_OPIMM, m_imm); end
  endtask

  task automatic test_rs2_usage();
    set_id(1, OP_LOAD, 5'd1, 5'd0, 5'd5, WB_MEM);
    tick();
    set_id(1, OP_STORE, 5'd2, 5'd5, 5'd0, NO_WB);
    n_vec++;
    if (bus.stall_op !== 1'b1)
      begin n_err++; $display("FAIL store_rs2_stall: stall=%b, required 1", bus.stall_op); end
    tick();
    tick();
    n_vec++;
    if (bus.idex_opcode_op !== OP_STORE || bus.idex_rs2_op !== 5'd5 || bus.idex_valid_op !== 1'b1)
      begin n_err++; $display("FAIL store_pass: op=%h rs2=%0d valid=%b, required %h 5 1",
        bus.idex_opcode_op, bus.idex_rs2_op, bus.idex_valid_op, OP_STORE); end
    set_id(1, OP_LOAD, 5'd1, 5'd0, 5'd5, WB_MEM);
    tick();
    set_id(1, OP_OPIMM, 5'd8, 5'd5, 5'd6, WB_ALU);
    n_vec++;
    if (bus.stall_op !== 1'b0)
      begin n_err++; $display("FAIL unused_rs2: stall=%b, required 0", bus.stall_op); end
    tick();
  endtask

  task automatic test_flush_hazard();
    logic [31:0] cnt0;
    set_id(1, OP_LOAD, 5'd1, 5'd0, 5'd5, WB_MEM);
    tick();
    cnt0 = stall_cnt;
    set_id(1, OP_OP, 5'd5, 5'd2, 5'd6, WB_ALU);
    bus.flush_ip = 1;
    #1;
    n_vec++;
    if (bus.stall_op !== 1'b0)
      begin n_err++; $display("FAIL flush_stall: stall=%b, required 0", bus.stall_op); end
    tick();
    bus.flush_ip = 0;
    n_vec++;
    if (bus.idex_valid_op !== 1'b0 || bus.idex_rd_op !== 5'd0 || stall_cnt !== cnt0)
      begin n_err++; $display("FAIL flush_bubble: valid=%b rd=%0d cnt=%0d, required 0 0 %0d",
        bus.idex_valid_op, bus.idex_rd_op, stall_cnt, cnt0); end
    set_id(1, OP_OP, 5'd5, 5'd2, 5'd9, WB_ALU);
    tick();
    n_vec++;
    if (bus.idex_valid_op !== 1'b1 || bus.idex_rd_op !== 5'd9)
      begin n_err++; $display("FAIL flush_run: valid=%b rd=%0d, required 1 9",
        bus.idex_valid_op, bus.idex_rd_op); end
  endtask

  task automatic test_reset_in_bubble();
    set_id(1, OP_LOAD, 5'd1, 5'd0, 5'd5, WB_MEM);
    tick();
    set_id(1, OP_OP, 5'd5, 5'd2, 5'd6, WB_ALU);
    tick();
    #1;
    reset = 1;
    model_reset();
    #1;
    n_vec++;
    if (bus.idex_valid_op !== 1'b0 || bus.idex_opcode_op !== 7'd0 || bus.idex_rs1_data_op !== 32'd0 ||
        bus.idex_pc_op !== 32'd0 || bus.stall_op !== 1'b0 || stall_cnt !== 32'd0)
      begin n_err++; $display("FAIL async_reset: valid=%b op=%h d1=%h pc=%h stall=%b cnt=%0d, required zeros",
        bus.idex_valid_op, bus.idex_opcode_op, bus.idex_rs1_data_op, bus.idex_pc_op, bus.stall_op,
        stall_cnt); end
    #1;
    reset = 0;
    tick();
    n_vec++;
    if (bus.idex_valid_op !== 1'b1 || bus.idex_opcode_op !== OP_OP || bus.idex_pc_op !== m_pc)
      begin n_err++; $display("FAIL post_reset_capture: valid=%b op=%h pc=%h, required 1 %h %h",
        bus.idex_valid_op, bus.idex_opcode_op, bus.idex_pc_op, OP_OP, m_pc); end
  endtask

  task automatic test_alu_stream();
    for (int i = 0; i < 4; i++) begin
      set_id(1, OP_OP, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
             5'($urandom_range(1, 31)), WB_ALU);
      n_vec++;
      if (bus.stall_op !== 1'b0)
        begin n_err++; $display("FAIL alu_stall[%0d]: stall=%b, required 0", i, bus.stall_op); end
      tick();
      n_vec++;
      if (bus.idex_valid_op !== 1'b1 || bus.idex_rs1_op !== m_rs1 || bus.idex_rs2_op !== m_rs2 ||
          bus.idex_rd_op !== m_rd || bus.idex_rs1_data_op !== m_d1 || bus.idex_rs2_data_op !== m_d2 ||
          bus.idex_imm_op !== m_imm || bus.idex_pc_op !== m_pc)
        begin n_err++; $display("FAIL alu_stream[%0d]: rd=%0d d1=%h d2=%h, required %0d %h %h",
          i, bus.idex_rd_op, bus.idex_rs1_data_op, bus.idex_rs2_data_op, m_rd, m_d1, m_d2); end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    logic held;
    ops = '{OP_LOAD, OP_OP, OP_OPIMM, OP_STORE, OP_BRANCH, OP_JALR, OP_LUI, OP_JAL};
    held = 0;
    for (int i = 0; i < 400; i++) begin
      if (!held) begin
        set_id(($urandom_range(0, 7) != 0), ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      bus.flush_ip = ($urandom_range(0, 7) == 0);
      #1;
      n_vec++;
      if (bus.stall_op !== model_stall())
        begin n_err++; $display("FAIL rand_stall[%0d]: stall=%b, required %b",
          i, bus.stall_op, model_stall()); end
      held = model_stall();
      tick();
      n_vec++;
      if (bus.idex_valid_op !== m_valid || bus.idex_opcode_op !== m_op || bus.idex_rd_op !== m_rd ||
          bus.idex_wb_mux_op !== m_wb ||
          (m_valid && (bus.idex_rs1_op !== m_rs1 || bus.idex_rs2_op !== m_rs2 ||
                       bus.idex_rs1_data_op !== m_d1 || bus.idex_rs2_data_op !== m_d2 ||
                       bus.idex_imm_op !== m_imm || bus.idex_pc_op !== m_pc)))
        begin n_err++; $display("FAIL rand_regs[%0d]: valid=%b op=%h rd=%0d wb=%0d, required %b %h %0d %0d",
          i, bus.idex_valid_op, bus.idex_opcode_op, bus.idex_rd_op, bus.idex_wb_mux_op,
          m_valid, m_op, m_rd, m_wb); end
`ifdef IDEX_STALL_CNT_EN
      n_vec++;
      if (stall_cnt !== m_cnt)
        begin n_err++; $display("FAIL rand_cnt[%0d]: cnt=%0d, required %0d", i, stall_cnt, m_cnt); end
`endif
    end
    bus.flush_ip = 0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_rs2_usage();
    test_flush_hazard();
    test_reset_in_bubble();
    test_alu_stream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
